// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux select arbiter: FSM state encoding,
// select-index width and number of arbitrated inputs.
package mux_arb_pkg;

    localparam int N_IN  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans req upward from start with
// wrap-around and returns the first set index plus an any-hit flag.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_IN-1:0] req_dbl;
    logic [N_IN-1:0]   req_rot;
    logic [SEL_W:0]    base;
    logic [SEL_W-1:0]  offset;

    // Doubling the vector turns the wrap-around scan into a plain slice.
    assign req_dbl = {req, req};
    assign base    = {1'b0, start};
    assign req_rot = req_dbl[base +: N_IN];

    // Lowest set bit of the rotated vector is the distance from start.
    always_comb begin
        offset = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign hit = |req;
    assign idx = start + offset;

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the select pair of a downstream 4:1 mux.
// A grant is held until ready, then priority rotates past the winner.
// A hold timeout withdraws a grant stalled for MAX_HOLD cycles.
// Build option: define MUX_SELECT_ARBITER_FIXED_PRI_EN for fixed priority
// (input 0 highest); the default build is round-robin.
module mux_select_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] req,
    input  logic            ready,
    output logic            address0,
    output logic            address1,
    output logic            sel_valid,
    output logic [N_IN-1:0] grant,
    output logic            timeout
);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [N_IN-1:0]    grant_reg, grant_next;
    logic               valid_reg, valid_next;
    logic               timeout_reg, timeout_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic               g_live;
    logic               hold_expired;
    logic               rearb;
    logic               pick_hit;
    logic [SEL_W-1:0]   pick_idx;
    logic [N_IN-1:0]    pick_onehot;

    assign g_live       = req[sel_reg];
    assign hold_expired = (cnt_reg == CNT_W'(MAX_HOLD - 1));

`ifdef MUX_SELECT_ARBITER_FIXED_PRI_EN
    // Fixed priority: the lowest-numbered requester always wins.
    always_comb begin
        pick_hit = |req;
        pick_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = SEL_W'(i);
            end
        end
    end
`else
    logic [SEL_W-1:0] last_reg;
    logic [SEL_W-1:0] pick_start;
    logic             advance;

    // The pointer moves onto the current grant when it completes or times
    // out; a dropped request leaves it untouched.
    assign advance = (state_reg == ST_GRANT) && (ready || (g_live && hold_expired));

    // Scan starts just past the most recently served input, using the
    // updated pointer when it moves on this same edge.
    always_comb begin
        pick_start = (advance ? sel_reg : last_reg) + SEL_W'(1);
    end

    // Last-granted pointer; 3 after reset so input 0 leads.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= SEL_W'(N_IN - 1);
        end else if (advance) begin
            last_reg <= sel_reg;
        end
    end

    rr_pick4 u_pick (
        .req   (req),
        .start (pick_start),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );
`endif

    // Decode the winner into the one-hot grant vector.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == SEL_W'(gi));
        end
    endgenerate

    // Next-state logic: hold, time out, or re-arbitrate on the current req.
    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        grant_next   = grant_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        cnt_next     = cnt_reg;
        rearb        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                rearb = 1'b1;
            end
            ST_GRANT: begin
                if (ready || !g_live || hold_expired) begin
                    rearb = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (!ready && g_live && hold_expired) begin
                    timeout_next = 1'b1;
                end
            end
        endcase

        if (rearb) begin
            cnt_next = '0;
            if (pick_hit) begin
                state_next = ST_GRANT;
                sel_next   = pick_idx;
                grant_next = pick_onehot;
                valid_next = 1'b1;
            end else begin
                state_next = ST_IDLE;
                grant_next = '0;
                valid_next = 1'b0;
            end
        end
    end

    // State and output registers; the select is retained while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            grant_reg   <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            grant_reg   <= grant_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign address0  = sel_reg[0];
    assign address1  = sel_reg[1];
    assign sel_valid = valid_reg;
    assign grant     = grant_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Self-checking bench for mux_select_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural arbiter model.
module tb_mux_select_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;
    logic       address0, address1, sel_valid, timeout;
    logic [3:0] grant;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state (plain integers).
    bit m_valid, m_to;
    int m_gnt, m_addr, m_last, m_hold;

    mux_select_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ready     (ready),
        .address0  (address0),
        .address1  (address1),
        .sel_valid (sel_valid),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {sel_valid, timeout, grant, address1, address0};
    endfunction

    function automatic logic [7:0] model_obs();
        logic [3:0] g;
        logic [1:0] a;
        g = m_valid ? (4'b0001 << m_gnt) : 4'b0000;
        a = 2'(m_addr);
        return {m_valid, m_to, g, a};
    endfunction

    // Winner for a request set: fixed priority or scan past the last winner.
    function automatic int pick(logic [3:0] r, int last);
`ifdef MUX_SELECT_ARBITER_FIXED_PRI_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    task automatic model_step();
        int w;
        bit re;
        if (reset) begin
            m_valid = 0; m_to = 0; m_gnt = 0; m_addr = 0; m_last = 3; m_hold = 0;
            return;
        end
        m_to = 0;
        re   = 1;
        if (m_valid) begin
            if (ready) m_last = m_gnt;
            else if (!req[m_gnt]) re = 1;
            else if (m_hold == MAX_HOLD - 1) begin m_to = 1; m_last = m_gnt; end
            else begin m_hold++; re = 0; end
        end
        if (re) begin
            w = pick(req, m_last);
            m_hold = 0;
            if (w >= 0) begin m_valid = 1; m_gnt = w; m_addr = w; end
            else m_valid = 0;
        end
    endtask

    // One clock: update the model with the applied inputs, then sample.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        $display("cyc %0d rst=%b req=%b rdy=%b -> valid=%b grant=%b addr=%b%b to=%b",
                 cyc, reset, req, ready, sel_valid, grant, address1, address0, timeout);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'b0000; ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs() !== 8'h00) $display("FAIL reset_state: got %b expected %b", obs(), 8'h00);
        else n_pass++;
    endtask

`ifndef MUX_SELECT_ARBITER_FIXED_PRI_EN
    task automatic test_rotate();
        logic [7:0] e;
        do_reset();
        req = 4'b1111; ready = 1'b1;
        n_checks++;
        if (sel_valid !== 1'b0) $display("FAIL rotate_latency: got %b expected 0", sel_valid);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            e = {1'b1, 1'b0, 4'b0001 << (k % 4), 2'(k % 4)};
            n_checks++;
            if (obs() !== e) $display("FAIL rotate_%0d: got %b expected %b", k, obs(), e);
            else n_pass++;
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        req = 4'b0100; ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs() !== 8'b1_0_0100_10) $display("FAIL hold_%0d: got %b expected %b", k, obs(), 8'b1_0_0100_10);
            else n_pass++;
        end
        req = 4'b0000; ready = 1'b1;
        tick();
        n_checks++;
        if (obs() !== 8'b0_0_0000_10) $display("FAIL hold_release: got %b expected %b", obs(), 8'b0_0_0000_10);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [3:0] eg;
        logic       et;
        do_reset();
        req = 4'b0011; ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            eg = (k >= 5 && k <= 8) ? 4'b0010 : 4'b0001;
            et = (k == 5 || k == 9);
            n_checks++;
            if ({grant, timeout} !== {eg, et})
                $display("FAIL timeout_%0d: got grant=%b to=%b expected grant=%b to=%b", k, grant, timeout, eg, et);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0100; ready = 1'b0;
        tick();
        req = 4'b1000;
        tick();
        n_checks++;
        if ({grant, timeout} !== 5'b1000_0)
            $display("FAIL drop: got grant=%b to=%b expected grant=1000 to=0", grant, timeout);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111; ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (obs() !== 8'h00) $display("FAIL reset_mid: got %b expected %b", obs(), 8'h00);
        else n_pass++;
        reset = 1'b0; ready = 1'b0;
        tick();
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL reset_regrant: got %b expected 0001", grant);
        else n_pass++;
    endtask
`else
    task automatic test_fixed();
        do_reset();
        req = 4'b1010; ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if ({sel_valid, grant} !== 5'b1_0010)
                $display("FAIL fixed_%0d: got valid=%b grant=%b expected valid=1 grant=0010", k, sel_valid, grant);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] e;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 63) == 0);
            req   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req;
            ready = ($urandom_range(0, 2) == 0);
            tick();
            e = model_obs();
            n_checks++;
            if (obs() !== e) $display("FAIL random_%0d: got %b expected %b", k, obs(), e);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
`ifndef MUX_SELECT_ARBITER_FIXED_PRI_EN
        test_rotate();
        test_single_hold();
        test_timeout();
        test_drop();
        test_reset_mid();
`else
        test_fixed();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
Name: mux_select_arbiter

Overview:
- Round-robin arbiter sitting directly upstream of the 4:1 multiplexer; converts four request lines into the mux select pair (address0 = select LSB, address1 = select MSB).
- Holds a select stable until the downstream consumer accepts the muxed bit (ready), then rotates priority.
- Includes a hold timeout so a stalled consumer cannot starve the other inputs.

Parameters:
- MAX_HOLD, 4, consecutive cycles in GRANT with ready low before a grant is forcibly withdrawn (legal range 1..15).
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  req[i] = input i of the mux has data to forward.
- ready  input  1  downstream has sampled the mux output this cycle.
- address0  output  1  mux select LSB, registered.
- address1  output  1  mux select MSB, registered.
- sel_valid  output  1  address0/address1 hold a live grant.
- grant  output  4  one-hot copy of the current grant; zero when sel_valid is 0.
- timeout  output  1  single-cycle pulse when a grant is withdrawn by the hold timeout.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: address0=0, address1=0, sel_valid=0, grant=0, timeout=0, state=IDLE, hold counter=0, last-granted pointer=3, so input 0 has top priority after reset.
- Register timing: all outputs are registered and change only on the rising edge of clk.
- Select encoding: select index = {address1,address0}. Index 1 means address0=1, address1=0.
- State IDLE: if req is nonzero, choose the first set req bit scanning upward from (last+1) mod 4 with wrap-around. Next edge: enter GRANT and drive address/grant/sel_valid. Latency from req to sel_valid is 1 cycle. If req is zero, stay in IDLE.
- GRANT with ready=1:
  - The transfer completes and last becomes the granted index.
  - Same edge: re-arbitrate on current req using the new pointer. If any req is set, stay in GRANT with the new select (back-to-back, no bubble). Otherwise go to IDLE with sel_valid=0.
  - The granted requester may be re-granted only if it is the sole requester.
- GRANT with ready=0 and granted req still high: the hold counter increments. When the counter reaches MAX_HOLD-1 with ready still 0:
  - Grant is withdrawn.
  - timeout pulses for 1 cycle.
  - last becomes the granted index, so the stalled input drops to lowest priority.
  - Re-arbitrate exactly as on ready.
- GRANT with granted req dropped while ready=0: withdraw without timeout pulse. last is unchanged. Re-arbitrate on the same edge.
- Simultaneous ready and req drop: treated as a completed transfer.
- Hold counter: cleared on every new grant and on leaving GRANT.
- Output rules: while sel_valid=0, address0/address1 retain their last value; only sel_valid qualifies them. grant is always one-hot or zero and always consistent with the address bits.
- Reset mid-operation: reset takes priority over all transitions. Outputs are at reset values after that edge, and any pending grant is lost.

Optional Feature:
- Macro: MUX_SELECT_ARBITER_FIXED_PRI_EN.
- Defined: fixed priority, lowest index wins (in0 > in1 > in2 > in3). The last pointer is not used. Timeout still withdraws the grant and pulses timeout, but the stalled input may be immediately re-granted if it is still the highest-priority requester.
- Undefined: round-robin exactly as described in Behaviour.

Decomposition:
- Shared package mux_arb_pkg:
  - State encoding constants ST_IDLE=1'b0 and ST_GRANT=1'b1.
  - Select-index width constant SEL_W=2.
  - Number of inputs N_IN=4.
- One sub-module: rr_pick4. It is purely combinational: given req[3:0] and a 2-bit start index, it returns any-hit plus a 2-bit winner index. It is instantiated once for arbitration. Under the macro it is replaced by a fixed-priority encoder path.

Test Plan:
- Reset, then req=4'b1111 held with ready=1 every cycle -> selects rotate 0,1,2,3,0 on consecutive cycles with sel_valid=1 continuously; one cycle of latency from first req to sel_valid.
- Only req=4'b0100, ready=0 for 2 cycles, then ready=1 -> address1=1, address0=0, grant=4'b0100 held 3 cycles; after ready, IDLE with sel_valid=0 and grant=0.
- req=4'b0011, ready tied 0 -> grant input 0 for 4 cycles; timeout pulses once; grant moves to input 1 on the same edge; after another 4 cycles grant returns to input 0.
- Grant input 2, drop req[2] with ready=0 while req=4'b1000 -> next edge grant=4'b1000, timeout stays 0.
- Assert reset while in GRANT with req=4'b1111 -> next edge all outputs 0; first grant after release goes to input 0.
- Macro defined, req=4'b1010, ready=1 continuously -> input 1 granted every cycle and input 3 is never granted.
